// File: rtl/cam_ctrl.sv
// cam_ctrl: 8-entry x 16-bit content-addressable table with a sequential lookup engine.
// Lookups scan one entry per cycle. The response reports a hit flag, the lowest
// matching index and a match count.
// Optional feature macro: CAM_CTRL_MULTI_MATCH_EN. When it is defined, every lookup
// scans all 8 entries and counts every match. When it is undefined, the scan stops
// at the first hit.
module cam_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_init_req,
   input  logic        i_wr_en,
   input  logic [2:0]  i_wr_addr,
   input  logic [15:0] i_wr_data,
   output logic        o_wr_ack,
   input  logic        i_lk_valid,
   input  logic [15:0] i_lk_key,
   output logic        o_lk_ready,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic        o_rsp_hit,
   output logic [2:0]  o_rsp_addr,
   output logic [3:0]  o_rsp_count,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      SCAN = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_nextState;

   logic [15:0] r_entry [8];
   logic [7:0]  r_valid;
   logic [15:0] r_key;
   logic [2:0]  r_idx;
   logic [2:0]  r_rspAddr;
   logic [3:0]  r_rspCount;

   logic        w_accInit;
   logic        w_accWr;
   logic        w_accLk;
   logic        w_match;
   logic        w_lastIdx;
   logic        w_rspValid;

   // r_idx is the INIT write pointer in INIT and the compare pointer in SCAN.
   assign w_match   = r_valid[r_idx] && (r_entry[r_idx] == r_key);
   assign w_lastIdx = (r_idx == 3'd7);

   // State register; reset returns to IDLE and abandons any operation in flight.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake decode.
   // In IDLE the priority is init, then write, then lookup.
   // Reset masks every acceptance in the cycle it is asserted.
   always_comb begin
      w_nextState = r_state;
      w_accInit   = 1'b0;
      w_accWr     = 1'b0;
      w_accLk     = 1'b0;
      o_lk_ready  = 1'b0;
      o_wr_ack    = 1'b0;
      w_rspValid  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!i_reset) begin
               if (i_init_req) begin
                  w_accInit   = 1'b1;
                  w_nextState = INIT;
               end else if (i_wr_en) begin
                  w_accWr  = 1'b1;
                  o_wr_ack = 1'b1;
               end else begin
                  o_lk_ready = 1'b1;
                  if (i_lk_valid) begin
                     w_accLk     = 1'b1;
                     w_nextState = SCAN;
                  end
               end
            end
         end
         INIT: begin
            if (w_lastIdx) begin
               w_nextState = IDLE;
            end
         end
         SCAN: begin
`ifdef CAM_CTRL_MULTI_MATCH_EN
            if (w_lastIdx) begin
               w_nextState = RESP;
            end
`else
            if (w_match || w_lastIdx) begin
               w_nextState = RESP;
            end
`endif
         end
         RESP: begin
            w_rspValid = !i_reset;
            if (i_rsp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Scan datapath: latch the key, walk the index, and accumulate the first-hit address and the match count.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_key      <= '0;
         r_idx      <= '0;
         r_rspAddr  <= '0;
         r_rspCount <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accInit) begin
                  r_idx <= '0;
               end
               if (w_accLk) begin
                  r_key      <= i_lk_key;
                  r_idx      <= '0;
                  r_rspAddr  <= '0;
                  r_rspCount <= '0;
               end
            end
            INIT: begin
               r_idx <= r_idx + 3'd1;
            end
            SCAN: begin
               if (w_match) begin
                  r_rspCount <= r_rspCount + 4'd1;
                  if (r_rspCount == 4'd0) begin
                     r_rspAddr <= r_idx;
                  end
               end
               r_idx <= r_idx + 3'd1;
            end
            default: begin
            end
         endcase
      end
   end

   // Valid bits: cleared by reset, set by a single write or by the matching INIT step.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_valid <= '0;
      end else if (w_accWr) begin
         r_valid[i_wr_addr] <= 1'b1;
      end else if (r_state == INIT) begin
         r_valid[r_idx] <= 1'b1;
      end
   end

   // Entry storage is deliberately not reset.
   // Clearing the valid bits is enough to hide stale contents.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         if (w_accWr) begin
            r_entry[i_wr_addr] <= i_wr_data;
         end else if (r_state == INIT) begin
            r_entry[r_idx] <= {13'd0, r_idx};
         end
      end
   end

   assign o_rsp_valid = w_rspValid;
   assign o_rsp_hit   = w_rspValid && (r_rspCount != 4'd0);
   assign o_rsp_addr  = w_rspValid ? r_rspAddr : 3'd0;
   assign o_rsp_count = w_rspValid ? r_rspCount : 4'd0;
   assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: self-checking bench for cam_ctrl.
// It applies fixed vectors against a known table, hand-written corner sequences,
// and random writes and lookups checked against a simple array model.
module tb_cam_ctrl;

`ifdef CAM_CTRL_MULTI_MATCH_EN
   localparam bit Multi = 1'b1;
`else
   localparam bit Multi = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        initReq;
   logic        wrEn;
   logic [2:0]  wrAddr;
   logic [15:0] wrData;
   logic        wrAck;
   logic        lkValid;
   logic [15:0] lkKey;
   logic        lkReady;
   logic        rspValid;
   logic        rspReady;
   logic        rspHit;
   logic [2:0]  rspAddr;
   logic [3:0]  rspCount;
   logic        busy;

   int checks = 0;
   int errors = 0;

   logic [15:0] mEntry [8];
   logic        mValid [8];

   typedef struct {
      logic [15:0] key;
      logic        hit;
      logic [2:0]  addr;
      logic [3:0]  cntMulti;
      logic [3:0]  cntSingle;
   } vec_t;

   vec_t vecs [6];

   cam_ctrl dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_init_req  (initReq),
      .i_wr_en     (wrEn),
      .i_wr_addr   (wrAddr),
      .i_wr_data   (wrData),
      .o_wr_ack    (wrAck),
      .i_lk_valid  (lkValid),
      .i_lk_key    (lkKey),
      .o_lk_ready  (lkReady),
      .o_rsp_valid (rspValid),
      .i_rsp_ready (rspReady),
      .o_rsp_hit   (rspHit),
      .o_rsp_addr  (rspAddr),
      .o_rsp_count (rspCount),
      .o_busy      (busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Backstop so a stuck design still ends the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic init, input logic wr, input logic [2:0] wa,
                                input logic [15:0] wd, input logic lv, input logic [15:0] lk,
                                input logic rr);
      initReq  = init;
      wrEn     = wr;
      wrAddr   = wa;
      wrData   = wd;
      lkValid  = lv;
      lkKey    = lk;
      rspReady = rr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int latencyFor(input logic hit, input logic [2:0] addr);
      if (Multi || !hit) return 9;
      return 2 + int'(addr);
   endfunction

   // Reference lookup: scan the model table with plain loops.
   function automatic void modelLookup(input logic [15:0] key, output logic hit,
                                       output logic [2:0] addr, output logic [3:0] cnt);
      int total = 0;
      int first = 0;
      for (int i = 0; i < 8; i++) begin
         if (mValid[i] && mEntry[i] == key) begin
            if (total == 0) first = i;
            total++;
         end
      end
      hit  = (total != 0);
      addr = hit ? 3'(first) : 3'd0;
      cnt  = Multi ? 4'(total) : (hit ? 4'd1 : 4'd0);
   endfunction

   task automatic doInit(input logic alsoWr, input logic alsoLk);
      int n = 0;
      applyStimulus(1'b1, alsoWr, 3'd1, 16'h1234, alsoLk, 16'h0005, 1'b0);
      #1;
      checkOutput("init wr_ack", wrAck, 0);
      checkOutput("init lk_ready", lkReady, 0);
      tick();
      applyStimulus(0, 0, 3'd0, 16'h0, 0, 16'h0, 0);
      while (busy && n < 20) begin
         n++;
         tick();
      end
      checkOutput("init busy cycles", n, 8);
      checkOutput("init no rsp_valid", rspValid, 0);
      for (int i = 0; i < 8; i++) begin
         mEntry[i] = 16'(i);
         mValid[i] = 1'b1;
      end
   endtask

   task automatic doWrite(input logic [2:0] addr, input logic [15:0] data);
      applyStimulus(0, 1, addr, data, 0, 16'h0, 0);
      #1;
      checkOutput("write wr_ack", wrAck, 1);
      tick();
      applyStimulus(0, 0, 3'd0, 16'h0, 0, 16'h0, 0);
      mEntry[addr] = data;
      mValid[addr] = 1'b1;
   endtask

   task automatic doLookup(input logic [15:0] key, input logic expHit, input logic [2:0] expAddr,
                           input logic [3:0] expCount, input int expLat, input int hold,
                           input string tag);
      int c = 1;
      applyStimulus(0, 0, 3'd0, 16'h0, 1, key, 0);
      #1;
      checkOutput({tag, " lk_ready"}, lkReady, 1);
      tick();
      applyStimulus(0, 0, 3'd0, 16'h0, 0, 16'h0, 0);
      while (!rspValid && c < 20) begin
         if (c == 1) checkOutput({tag, " outputs zero before resp"}, {rspHit, rspAddr, rspCount}, 0);
         tick();
         c++;
      end
      if (!rspValid) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: no rsp_valid within %0d cycles", tag, c);
         return;
      end
      checkOutput({tag, " latency"}, c, expLat);
      checkOutput({tag, " rsp_hit"}, rspHit, expHit);
      checkOutput({tag, " rsp_addr"}, rspAddr, expAddr);
      checkOutput({tag, " rsp_count"}, rspCount, expCount);
      for (int h = 0; h < hold; h++) begin
         applyStimulus(0, 1, expAddr, 16'hAAAA, 1, 16'h0004, 0);
         #1;
         checkOutput({tag, " hold lk_ready"}, lkReady, 0);
         checkOutput({tag, " hold wr_ack"}, wrAck, 0);
         checkOutput({tag, " hold rsp stable"}, {rspValid, rspHit, rspAddr, rspCount},
                     {1'b1, expHit, expAddr, expCount});
         tick();
      end
      applyStimulus(0, 0, 3'd0, 16'h0, 0, 16'h0, 1);
      tick();
      applyStimulus(0, 0, 3'd0, 16'h0, 0, 16'h0, 0);
      checkOutput({tag, " idle after handshake"}, {busy, rspValid}, 0);
   endtask

   task automatic doModelLookup(input logic [15:0] key, input string tag);
      logic       h;
      logic [2:0] a;
      logic [3:0] n;
      modelLookup(key, h, a, n);
      doLookup(key, h, a, n, latencyFor(h, a), 0, tag);
   endtask

   // Main sequence.
   initial begin
      int seen;
      logic [15:0] rk;

      // Table after init plus entry2 = entry6 = 3: {0,1,3,3,4,5,3,7}.
      vecs[0] = '{key: 16'h0005, hit: 1'b1, addr: 3'd5, cntMulti: 4'd1, cntSingle: 4'd1};
      vecs[1] = '{key: 16'h0003, hit: 1'b1, addr: 3'd2, cntMulti: 4'd3, cntSingle: 4'd1};
      vecs[2] = '{key: 16'hBEEF, hit: 1'b0, addr: 3'd0, cntMulti: 4'd0, cntSingle: 4'd0};
      vecs[3] = '{key: 16'h0000, hit: 1'b1, addr: 3'd0, cntMulti: 4'd1, cntSingle: 4'd1};
      vecs[4] = '{key: 16'h0007, hit: 1'b1, addr: 3'd7, cntMulti: 4'd1, cntSingle: 4'd1};
      vecs[5] = '{key: 16'h0002, hit: 1'b0, addr: 3'd0, cntMulti: 4'd0, cntSingle: 4'd0};

      for (int i = 0; i < 8; i++) begin
         mEntry[i] = 16'h0;
         mValid[i] = 1'b0;
      end

      applyStimulus(0, 0, 3'd0, 16'h0, 0, 16'h0, 0);
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      checkOutput("reset busy", busy, 0);
      checkOutput("reset rsp outputs", {rspValid, rspHit, rspAddr, rspCount}, 0);
      checkOutput("reset wr_ack", wrAck, 0);
      checkOutput("reset lk_ready", lkReady, 1);

      // init, write and lookup requested together: only the init is taken.
      doInit(1'b1, 1'b1);
      doLookup(16'h0005, 1'b1, 3'd5, 4'd1, Multi ? 9 : 7, 0, "key5");
      doLookup(16'h1234, 1'b0, 3'd0, 4'd0, 9, 0, "ignored write");

      doWrite(3'd2, 16'h0003);
      doWrite(3'd6, 16'h0003);
      for (int i = 0; i < 6; i++) begin
         doLookup(vecs[i].key, vecs[i].hit, vecs[i].addr,
                  Multi ? vecs[i].cntMulti : vecs[i].cntSingle,
                  latencyFor(vecs[i].hit, vecs[i].addr), 0, $sformatf("vec%0d", i));
      end

      // Hold the response for 5 cycles while a write and a lookup are attempted.
      doLookup(16'h0004, 1'b1, 3'd4, 4'd1, latencyFor(1'b1, 3'd4), 5, "hold");
      doLookup(16'hAAAA, 1'b0, 3'd0, 4'd0, 9, 0, "hold write ignored");
      doLookup(16'h0004, 1'b1, 3'd4, 4'd1, latencyFor(1'b1, 3'd4), 0, "hold entry kept");

      // Random writes, lookups and re-inits compared against the model.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 5))
            0, 1: doWrite(3'($urandom_range(0, 7)), 16'($urandom_range(0, 9)));
            2: doInit(1'b0, 1'b0);
            default: begin
               rk = 16'($urandom_range(0, 11));
               doModelLookup(rk, $sformatf("rand%0d key%0d", i, rk));
            end
         endcase
      end

      // Reset in the middle of a scan: no response appears and all valid bits are cleared.
      applyStimulus(0, 0, 3'd0, 16'h0, 1, 16'h0007, 0);
      tick();
      applyStimulus(0, 0, 3'd0, 16'h0, 0, 16'h0, 0);
      repeat (2) tick();
      checkOutput("mid-scan busy", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checkOutput("post-reset busy", busy, 0);
      checkOutput("post-reset lk_ready", lkReady, 1);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (rspValid) seen++;
         tick();
      end
      checkOutput("aborted scan rsp_valid count", seen, 0);
      for (int i = 0; i < 8; i++) mValid[i] = 1'b0;
      doLookup(16'h0000, 1'b0, 3'd0, 4'd0, 9, 0, "after reset key0");
      doModelLookup(16'h0003, "after reset key3");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
